// File: rtl/iob_fifo_dp_ctrl_pkg.sv
// Shared definitions for the dual-port FIFO controller.
//   DEPTH      : default FIFO depth (2**ADDR_W_DEF words)
//   be_width   : byte-enable width for a given word width
//   fifo_depth : number of words for a given address width
package iob_fifo_dp_ctrl_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/iob_fifo_ptr_lvl.sv
// Pointer/occupancy tracker for the dual-port FIFO.
//   clk_i, arst_i      : clock, async active-high reset
//   w_en_i, r_en_i     : raw push/pop requests
//   push_o, pop_o      : accepted push/pop this cycle
//   wptr_o, rptr_o     : write/read RAM addresses (wrap naturally)
//   level_o            : occupancy 0..2**ADDR_W
//   full_o, empty_o    : flags decoded from level
//   ovf_o, udf_o       : sticky rejected-push / rejected-pop flags
module iob_fifo_ptr_lvl
  import iob_fifo_dp_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              w_en_i,
  input  logic              r_en_i,
  output logic              push_o,
  output logic              pop_o,
  output logic [ADDR_W-1:0] wptr_o,
  output logic [ADDR_W-1:0] rptr_o,
  output logic [ADDR_W:0]   level_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ovf_o,
  output logic              udf_o
);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(fifo_depth(ADDR_W));

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              full, empty, push, pop;

  always_comb begin
    full    = (level_q == FULL_LVL);
    empty   = (level_q == '0);
    // Flags come from the registered level, so a simultaneous push+pop
    // at full/empty resolves in favour of the side that can proceed.
    push    = w_en_i & ~full;
    pop     = r_en_i & ~empty;
    wptr_d  = wptr_q + ADDR_W'(push);
    rptr_d  = rptr_q + ADDR_W'(pop);
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ovf_d   = ovf_q | (w_en_i & full);
    udf_d   = udf_q | (r_en_i & empty);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign push_o  = push;
  assign pop_o   = pop;
  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign level_o = level_q;
  assign full_o  = full;
  assign empty_o = empty;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;
endmodule

// File: rtl/iob_fifo_dp_ctrl.sv
// FIFO controller for an external dual-port byte-enable RAM.
// Port A writes (push), port B reads (pop, one-cycle RAM latency).
//   clk_i, arst_i               : clock, async active-high reset
//   w_en_i, w_data_i, w_full_o  : push side
//   r_en_i, r_data_o, r_valid_o, r_empty_o : pop side
//   level_o, ovf_o, udf_o       : occupancy and sticky error flags
//   ext_mem_*A_o                : RAM write port controls/data
//   ext_mem_*B_o, ext_mem_dB_i  : RAM read port controls/data
module iob_fifo_dp_ctrl
  import iob_fifo_dp_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   w_en_i,
  input  logic [DATA_W-1:0]      w_data_i,
  output logic                   w_full_o,
  input  logic                   r_en_i,
  output logic [DATA_W-1:0]      r_data_o,
  output logic                   r_valid_o,
  output logic                   r_empty_o,
  output logic [ADDR_W:0]        level_o,
  output logic                   ovf_o,
  output logic                   udf_o,
  output logic                   ext_mem_enA_o,
  output logic [DATA_W/8-1:0]    ext_mem_weA_o,
  output logic [ADDR_W-1:0]      ext_mem_addrA_o,
  output logic [DATA_W-1:0]      ext_mem_dA_o,
  output logic                   ext_mem_enB_o,
  output logic [DATA_W/8-1:0]    ext_mem_weB_o,
  output logic [ADDR_W-1:0]      ext_mem_addrB_o,
  input  logic [DATA_W-1:0]      ext_mem_dB_i
);
  localparam int BE_W = be_width(DATA_W);

  logic              push, pop;
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [DATA_W-1:0] d_a_q, d_a_d;
  logic              r_valid_q, r_valid_d;

  iob_fifo_ptr_lvl #(.ADDR_W(ADDR_W)) u_ptr_lvl (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .w_en_i  (w_en_i),
    .r_en_i  (r_en_i),
    .push_o  (push),
    .pop_o   (pop),
    .wptr_o  (wptr),
    .rptr_o  (rptr),
    .level_o (level_o),
    .full_o  (w_full_o),
    .empty_o (r_empty_o),
    .ovf_o   (ovf_o),
    .udf_o   (udf_o)
  );

  // Port A address/data pass through on a push and otherwise hold the last
  // written values, so the RAM inputs only move when a write happens.
  always_comb begin
    addr_a_d  = push ? wptr : addr_a_q;
    d_a_d     = push ? w_data_i : d_a_q;
    r_valid_d = pop;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      addr_a_q  <= '0;
      d_a_q     <= '0;
      r_valid_q <= 1'b0;
    end else begin
      addr_a_q  <= addr_a_d;
      d_a_q     <= d_a_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign ext_mem_enA_o   = push;
  assign ext_mem_weA_o   = {BE_W{push}};
  assign ext_mem_addrA_o = addr_a_d;
  assign ext_mem_dA_o    = d_a_d;
  assign ext_mem_enB_o   = pop;
  assign ext_mem_weB_o   = '0;
  assign ext_mem_addrB_o = rptr;
  assign r_data_o        = ext_mem_dB_i;
  assign r_valid_o       = r_valid_q;
endmodule
